src_operand_buffer: RTL and testbench
=====================================

# src_operand_buffer

Per-PE operand buffer that sits directly upstream of the compute-stall logic. It holds data arriving from the PE neighbour, PU neighbour, PE bus and global bus in four small FIFOs. It presents each FIFO's head word and valid flag to the stall/operand-select stage, and pops a head only when the compute instruction that reads it actually issues. Producers see a per-channel ready so no word is ever dropped.

## Interface
Parameters:
- dataLen, 16: operand word width.
- srcNum, 3: namespace select width; decoder one-hots are 1<<srcNum wide.
- indexLen, 8: source index width.
- logDepth, 1: log2 of FIFO depth per channel (default depth 2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pe_neigh_in, pu_neigh_in, pe_bus_in, gb_bus_in  in  dataLen each  producer data, one per channel.
- pe_neigh_in_v, pu_neigh_in_v, pe_bus_in_v, gb_bus_in_v  in  1 each  producer valid.
- pe_neigh_rdy, pu_neigh_rdy, pe_bus_rdy, gb_bus_rdy  out  1 each  channel not full.
- src0_decoder_out, src1_decoder_out  in  1<<srcNum  one-hot namespace of each source.
- src0Index, src1Index  in  indexLen  bit0 selects channel within a namespace: 0 = PE, 1 = PU/GB.
- inst_valid  in  1  current instruction valid.
- inst_stall  in  1  final stall of the current instruction.
- pe_neigh_data_reg, pu_neigh_data_reg, pe_bus_data_reg, gb_bus_data_reg  out  dataLen each  FIFO heads.
- pe_neigh_data_reg_v, pu_neigh_data_reg_v, pe_bus_data_reg_v, gb_bus_data_reg_v  out  1 each  head valid (count != 0).

## Operation
- Four independent circular FIFOs, each with depth D = 1<<logDepth. Each has a write pointer, a read pointer (both logDepth bits, wrapping modulo D) and a count (logDepth+1 bits, range 0..D).
- Push: in_v && rdy. The word is written at the write pointer, the write pointer increments and count increments.
- in_v while rdy=0 has no effect. The producer must hold the word; the buffer does not latch it.
- rdy = (count != D). rdy depends only on registered count, with no pop bypass. A full FIFO therefore accepts nothing in the cycle it is popped.
- Issue: inst_valid && ~inst_stall.
- Channel selection:
  - pe_neigh: NAMESPACE_NEIGHBOR && index[0]=0.
  - pu_neigh: NAMESPACE_NEIGHBOR && index[0]=1.
  - pe_bus: NAMESPACE_BUS && index[0]=0.
  - gb_bus: NAMESPACE_BUS && index[0]=1.
- Pop of a channel: issue && (src0 selects it || src1 selects it) && count != 0. The read pointer increments and count decrements.
- src0 and src1 selecting the same channel produces exactly one pop, and both operands read the same head.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pop requested while count==0: ignored. This is not reachable while the stall logic is correct, and assertions flag it.
- Head output = mem[read pointer]. It is don't-care when valid=0, but reads 0 after reset.
- Other namespaces (interim, BRAM) never pop.

## Timing
- Reset (synchronous, while reset=1 at the clk edge):
  - All pointers and counts are 0 and all storage is cleared.
  - All *_data_reg_v outputs are 0 and all *_data_reg outputs are 0.
  - All *_rdy outputs are 1 from the first cycle after reset.
- Reset mid-operation discards all buffered words.
- Push-to-visible latency is 1 cycle: a word pushed at edge N is on the head with valid=1 after edge N. There is no combinational path from in_v to data_reg_v.
- Pop takes effect at the issuing edge. The next head, or valid=0, appears after that edge.
- All outputs are registered or decoded from registered state. The only combinational inputs are decoder_out, index, inst_valid and inst_stall, and they feed pop enable only.
- Sustained throughput is one word per cycle per channel when push and pop overlap.

## Test plan
- Reset then idle: all *_v=0, all data=0, all rdy=1. Hold reset=1 for 3 cycles mid-traffic with 2 words queued in pe_bus: afterwards pe_bus_data_reg_v=0.
- Push 0x0011 to pu_neigh with no reads: pu_neigh_data_reg_v=1 and data=0x0011 one cycle later. Hold inst_valid=1 with src0=NEIGHBOR, index=1, inst_stall=1 for 4 cycles: the word stays. Drop the stall: the word pops and v=0 next cycle.
- Fill gb_bus with 0xA, 0xB (D=2): gb_bus_rdy=0. Push 0xC while full: no effect. Pop once: head=0xB and rdy=1.
- src0 and src1 both NEIGHBOR index 0, pe_neigh holding 0x5, 0x6: one issue pops once and the head becomes 0x6. It does not become empty.
- src0=BUS idx0, src1=NEIGHBOR idx1, both valid, plus a simultaneous push to pe_bus: pe_bus count unchanged and pu_neigh count decrements.
- Continuous push/pop on pe_neigh for 16 cycles with incrementing data 1..16: the heads are observed in order with no loss across pointer wrap.

Source files
------------

// File: rtl/src_operand_buffer.sv
// Per-PE operand buffer: four small circular FIFOs (PE/PU neighbour, PE/global bus)
// whose heads feed operand select; a head pops only when the reading instruction issues.
module src_operand_buffer #(
    parameter int dataLen  = 16,
    parameter int srcNum   = 3,
    parameter int indexLen = 8,
    parameter int logDepth = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [dataLen-1:0]       pe_neigh_in,
    input  logic [dataLen-1:0]       pu_neigh_in,
    input  logic [dataLen-1:0]       pe_bus_in,
    input  logic [dataLen-1:0]       gb_bus_in,
    input  logic                     pe_neigh_in_v,
    input  logic                     pu_neigh_in_v,
    input  logic                     pe_bus_in_v,
    input  logic                     gb_bus_in_v,
    output logic                     pe_neigh_rdy,
    output logic                     pu_neigh_rdy,
    output logic                     pe_bus_rdy,
    output logic                     gb_bus_rdy,
    input  logic [(1<<srcNum)-1:0]   src0_decoder_out,
    input  logic [(1<<srcNum)-1:0]   src1_decoder_out,
    input  logic [indexLen-1:0]      src0Index,
    input  logic [indexLen-1:0]      src1Index,
    input  logic                     inst_valid,
    input  logic                     inst_stall,
    output logic [dataLen-1:0]       pe_neigh_data_reg,
    output logic [dataLen-1:0]       pu_neigh_data_reg,
    output logic [dataLen-1:0]       pe_bus_data_reg,
    output logic [dataLen-1:0]       gb_bus_data_reg,
    output logic                     pe_neigh_data_reg_v,
    output logic                     pu_neigh_data_reg_v,
    output logic                     pe_bus_data_reg_v,
    output logic                     gb_bus_data_reg_v
);
    localparam int unsigned NCH         = 4;
    localparam int unsigned D           = 1 << logDepth;
    localparam int unsigned NS_NEIGHBOR = 1;
    localparam int unsigned NS_BUS      = 2;
    localparam logic [logDepth:0] FULL  = (logDepth+1)'(D);

    logic [dataLen-1:0]  in_data [NCH];
    logic [NCH-1:0]      in_v, push, pop_req, pop;
    logic [dataLen-1:0]  mem_q   [NCH][D];
    logic [logDepth-1:0] wptr_q  [NCH];
    logic [logDepth-1:0] wptr_d  [NCH];
    logic [logDepth-1:0] rptr_q  [NCH];
    logic [logDepth-1:0] rptr_d  [NCH];
    logic [logDepth:0]   cnt_q   [NCH];
    logic [logDepth:0]   cnt_d   [NCH];
    logic                issue, s0_nb, s0_bus, s1_nb, s1_bus;
    logic                unused_inputs;

    assign in_data[0] = pe_neigh_in;
    assign in_data[1] = pu_neigh_in;
    assign in_data[2] = pe_bus_in;
    assign in_data[3] = gb_bus_in;
    assign in_v = {gb_bus_in_v, pe_bus_in_v, pu_neigh_in_v, pe_neigh_in_v};

    assign issue  = inst_valid & ~inst_stall;
    assign s0_nb  = src0_decoder_out[NS_NEIGHBOR];
    assign s0_bus = src0_decoder_out[NS_BUS];
    assign s1_nb  = src1_decoder_out[NS_NEIGHBOR];
    assign s1_bus = src1_decoder_out[NS_BUS];

    // Both sources naming the same channel collapse into a single pop.
    assign pop_req[0] = issue & ((s0_nb  & ~src0Index[0]) | (s1_nb  & ~src1Index[0]));
    assign pop_req[1] = issue & ((s0_nb  &  src0Index[0]) | (s1_nb  &  src1Index[0]));
    assign pop_req[2] = issue & ((s0_bus & ~src0Index[0]) | (s1_bus & ~src1Index[0]));
    assign pop_req[3] = issue & ((s0_bus &  src0Index[0]) | (s1_bus &  src1Index[0]));

    always_comb begin
        push = '0;
        pop  = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            push[c]   = in_v[c] && (cnt_q[c] != FULL);
            pop[c]    = pop_req[c] && (cnt_q[c] != '0);
            wptr_d[c] = wptr_q[c] + logDepth'(push[c]);
            rptr_d[c] = rptr_q[c] + logDepth'(pop[c]);
            cnt_d[c]  = cnt_q[c] + (logDepth+1)'(push[c]) - (logDepth+1)'(pop[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                cnt_q[c]  <= '0;
                for (int unsigned i = 0; i < D; i++) begin
                    mem_q[c][i] <= '0;
                end
            end
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                wptr_q[c] <= wptr_d[c];
                rptr_q[c] <= rptr_d[c];
                cnt_q[c]  <= cnt_d[c];
                if (push[c]) begin
                    mem_q[c][wptr_q[c]] <= in_data[c];
                end
            end
        end
    end

    assign pe_neigh_rdy = (cnt_q[0] != FULL);
    assign pu_neigh_rdy = (cnt_q[1] != FULL);
    assign pe_bus_rdy   = (cnt_q[2] != FULL);
    assign gb_bus_rdy   = (cnt_q[3] != FULL);

    assign pe_neigh_data_reg = mem_q[0][rptr_q[0]];
    assign pu_neigh_data_reg = mem_q[1][rptr_q[1]];
    assign pe_bus_data_reg   = mem_q[2][rptr_q[2]];
    assign gb_bus_data_reg   = mem_q[3][rptr_q[3]];

    assign pe_neigh_data_reg_v = (cnt_q[0] != '0);
    assign pu_neigh_data_reg_v = (cnt_q[1] != '0);
    assign pe_bus_data_reg_v   = (cnt_q[2] != '0);
    assign gb_bus_data_reg_v   = (cnt_q[3] != '0);

    // Only bit0 of each index and two namespace bits steer the pops.
    assign unused_inputs = ^{src0Index, src1Index, src0_decoder_out, src1_decoder_out};

    for (genvar g = 0; g < NCH; g++) begin : g_chk
        assert property (@(posedge clk) disable iff (reset) !(pop_req[g] && cnt_q[g] == '0));
    end
endmodule

// File: tb/tb_src_operand_buffer.sv
// Randomised and directed bench for src_operand_buffer: a queue-per-channel reference
// model predicts each cycle's heads; a negedge monitor pops the scoreboard and compares.
module tb_src_operand_buffer;
    localparam int D           = 2;
    localparam int NS_INTERIM  = 0;
    localparam int NS_NEIGHBOR = 1;
    localparam int NS_BUS      = 2;
    localparam int NS_BRAM     = 3;

    typedef struct packed {
        bit              zero;
        logic [3:0]      v;
        logic [3:0]      rdy;
        logic [3:0][15:0] d;
    } exp_t;

    logic        clk = 0;
    logic        reset = 1;
    logic [15:0] din [4];
    logic [3:0]  din_v = '0;
    logic [7:0]  s0dec = '0, s1dec = '0;
    logic [7:0]  s0idx = '0, s1idx = '0;
    logic        inst_valid = 0, inst_stall = 0;
    logic [3:0]  rdy, av;
    logic [15:0] ad [4];

    logic [15:0] mq [4][$];
    exp_t        sb [$];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    src_operand_buffer #(.dataLen(16), .srcNum(3), .indexLen(8), .logDepth(1)) dut (
        .clk(clk), .reset(reset),
        .pe_neigh_in(din[0]), .pu_neigh_in(din[1]), .pe_bus_in(din[2]), .gb_bus_in(din[3]),
        .pe_neigh_in_v(din_v[0]), .pu_neigh_in_v(din_v[1]),
        .pe_bus_in_v(din_v[2]), .gb_bus_in_v(din_v[3]),
        .pe_neigh_rdy(rdy[0]), .pu_neigh_rdy(rdy[1]), .pe_bus_rdy(rdy[2]), .gb_bus_rdy(rdy[3]),
        .src0_decoder_out(s0dec), .src1_decoder_out(s1dec),
        .src0Index(s0idx), .src1Index(s1idx),
        .inst_valid(inst_valid), .inst_stall(inst_stall),
        .pe_neigh_data_reg(ad[0]), .pu_neigh_data_reg(ad[1]),
        .pe_bus_data_reg(ad[2]), .gb_bus_data_reg(ad[3]),
        .pe_neigh_data_reg_v(av[0]), .pu_neigh_data_reg_v(av[1]),
        .pe_bus_data_reg_v(av[2]), .gb_bus_data_reg_v(av[3])
    );

    // Channel c lives in namespace NEIGHBOR (c<2) or BUS, picked by index bit0 == c bit0.
    function automatic bit selects(input logic [7:0] dec, input logic [7:0] idx, input int c);
        int ns;
        ns = (c < 2) ? NS_NEIGHBOR : NS_BUS;
        return (dec == (8'd1 << ns)) && (idx[0] == c[0]);
    endfunction

    function automatic bit wants(input int c);
        return inst_valid && !inst_stall && (selects(s0dec, s0idx, c) || selects(s1dec, s1idx, c));
    endfunction

    task automatic cycle();
        bit   pop [4];
        bit   push [4];
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            pop[c]  = wants(c) && (mq[c].size() > 0);
            push[c] = din_v[c] && (mq[c].size() < D);
        end
        @(posedge clk);
        e = '0;
        if (reset) begin
            for (int c = 0; c < 4; c++) mq[c].delete();
            e.zero = 1;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (pop[c])  void'(mq[c].pop_front());
                if (push[c]) mq[c].push_back(din[c]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            e.v[c]   = mq[c].size() > 0;
            e.rdy[c] = mq[c].size() < D;
            e.d[c]   = (mq[c].size() > 0) ? mq[c][0] : 16'h0;
        end
        sb.push_back(e);
        #1;
    endtask

    task automatic chk(input string name, input int c, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s ch%0d at %0t: got %h expected %h", name, c, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int c = 0; c < 4; c++) begin
                chk("valid", c, {15'h0, av[c]}, {15'h0, e.v[c]});
                chk("rdy", c, {15'h0, rdy[c]}, {15'h0, e.rdy[c]});
                if (e.v[c] || e.zero) chk("data", c, ad[c], e.d[c]);
            end
        end
    end

    task automatic set_src(input int ns0, input int i0, input int ns1, input int i1);
        s0dec = 8'd1 << ns0; s0idx = 8'(i0);
        s1dec = 8'd1 << ns1; s1idx = 8'(i1);
    endtask

    task automatic push1(input int c, input logic [15:0] w);
        din[c] = w; din_v[c] = 1; cycle(); din_v[c] = 0;
    endtask

    task automatic issue1();
        inst_valid = 1; inst_stall = 0; cycle(); inst_valid = 0;
    endtask

    initial begin
        for (int c = 0; c < 4; c++) din[c] = '0;
        set_src(NS_INTERIM, 0, NS_INTERIM, 0);
        repeat (2) cycle();
        reset = 0;
        repeat (2) cycle();

        // Single word to pu_neigh, held under stall, then popped.
        push1(1, 16'h0011);
        set_src(NS_NEIGHBOR, 1, NS_INTERIM, 0);
        inst_valid = 1; inst_stall = 1;
        repeat (4) cycle();
        inst_stall = 0; cycle();
        inst_valid = 0; cycle();

        // Fill gb_bus, push while full, pop once, drain.
        push1(3, 16'h000A);
        push1(3, 16'h000B);
        push1(3, 16'h000C);
        set_src(NS_BUS, 1, NS_BRAM, 1);
        issue1();
        cycle();
        issue1();

        // Both sources on pe_neigh: one pop per issue.
        push1(0, 16'h0005);
        push1(0, 16'h0006);
        set_src(NS_NEIGHBOR, 0, NS_NEIGHBOR, 0);
        issue1();
        cycle();
        issue1();

        // Pops on pe_bus and pu_neigh with a simultaneous pe_bus push.
        din[2] = 16'h0021; din[1] = 16'h0031; din_v = 4'b0110; cycle(); din_v = '0;
        set_src(NS_BUS, 0, NS_NEIGHBOR, 1);
        din[2] = 16'h0022; din_v[2] = 1;
        issue1();
        din_v = '0;
        set_src(NS_BUS, 0, NS_INTERIM, 0);
        issue1();

        // Streaming pe_neigh across pointer wrap.
        set_src(NS_NEIGHBOR, 0, NS_INTERIM, 0);
        for (int k = 1; k <= 16; k++) begin
            din[0] = 16'(k); din_v[0] = 1;
            inst_valid = (k > 1); inst_stall = 0;
            cycle();
        end
        din_v = '0;
        issue1();

        // Random traffic; stall forced where an issue would hit an empty channel.
        for (int n = 0; n < 300; n++) begin
            int ns0, ns1;
            for (int c = 0; c < 4; c++) din[c] = 16'($urandom);
            din_v = 4'($urandom);
            ns0 = $urandom_range(0, 3); ns1 = $urandom_range(0, 3);
            set_src(ns0, $urandom_range(0, 255), ns1, $urandom_range(0, 255));
            inst_valid = $urandom_range(0, 3) != 0;
            inst_stall = $urandom_range(0, 3) == 0;
            for (int c = 0; c < 4; c++)
                if (wants(c) && mq[c].size() == 0) inst_stall = 1;
            cycle();
        end
        din_v = '0; inst_valid = 0; inst_stall = 0;

        // Reset with traffic queued in pe_bus.
        for (int c = 0; c < 4; c++) if (mq[c].size() == D) begin
            set_src((c < 2) ? NS_NEIGHBOR : NS_BUS, c % 2, NS_INTERIM, 0);
            issue1();
        end
        set_src(NS_INTERIM, 0, NS_INTERIM, 0);
        if (mq[2].size() > 0) begin
            set_src(NS_BUS, 0, NS_INTERIM, 0);
            issue1();
            if (mq[2].size() > 0) issue1();
            set_src(NS_INTERIM, 0, NS_INTERIM, 0);
        end
        push1(2, 16'h0101);
        push1(2, 16'h0102);
        reset = 1;
        repeat (3) cycle();
        reset = 0;
        repeat (2) cycle();

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
